// File: rtl/lap_load_ctl_pkg.sv
// lap_load_ctl_pkg: shared types and widths for the LAP cache load sequencer.
package lap_load_ctl_pkg;

    function automatic int imax(input int a, input int b);
        return a > b ? a : b;
    endfunction

    localparam int LAP_N           = 4;
    localparam int LAP_SA_ALUWIDTH = 16;
    localparam int LAP_COL_ADR_W   = 6;
    localparam int LAP_ROW_ADR_W   = 6;
    localparam int LAP_PAR_ADR_W   = 8;
    localparam int LAP_LOAD_ADR_W  = imax(imax(LAP_COL_ADR_W, LAP_ROW_ADR_W), LAP_PAR_ADR_W);
    // One extra bit so a full bank (2^ADR_W words) can be described.
    localparam int LAP_LOAD_LEN_W  = LAP_LOAD_ADR_W + 1;

    typedef enum logic [1:0] {COL, ROW, PART, ILL} load_tgt_t;

    typedef struct packed {
        load_tgt_t                   tgt;
        logic [$clog2(LAP_N)-1:0]    bank;
        logic [LAP_LOAD_ADR_W-1:0]   adr;
        logic [LAP_LOAD_LEN_W-1:0]   len;
    } load_desc_t;

    typedef enum logic [1:0] {IDLE, QUIESCE, LOAD, DONE} load_state_t;

endpackage

// File: rtl/lap_load_wgen.sv
// lap_load_wgen: latched descriptor, address/count tracking and registered bank write strobes.
module lap_load_wgen
    import lap_load_ctl_pkg::*;
#(
    parameter int N      = LAP_N,
    parameter int ADR_W  = LAP_LOAD_ADR_W,
    parameter int DATA_W = 32,
    parameter int LEN_W  = LAP_LOAD_LEN_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ld,
    input  logic [1:0]           desc_tgt,
    input  logic [$clog2(N)-1:0] desc_bank,
    input  logic [ADR_W-1:0]     desc_adr,
    input  logic [LEN_W-1:0]     desc_len,
    input  logic                 bcast,
    input  logic                 hs,
    input  logic [DATA_W-1:0]    dat,
    output logic [N-1:0]         col_wen,
    output logic [N-1:0]         row_wen,
    output logic [N-1:0]         par_wen,
    output logic [ADR_W-1:0]     wadr,
    output logic [DATA_W-1:0]    wdata,
    output logic                 last
);

    load_tgt_t        tgt;
    logic [N-1:0]     mask;
    logic [ADR_W-1:0] adr;
    logic [LEN_W-1:0] cnt;

    assign last = cnt == LEN_W'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            tgt     <= COL;
            mask    <= '0;
            adr     <= '0;
            cnt     <= '0;
            col_wen <= '0;
            row_wen <= '0;
            par_wen <= '0;
            wadr    <= '0;
            wdata   <= '0;
        end else begin
            col_wen <= (hs && tgt == COL)  ? mask : '0;
            row_wen <= (hs && tgt == ROW)  ? mask : '0;
            par_wen <= (hs && tgt == PART) ? mask : '0;
            if (ld) begin
                tgt  <= load_tgt_t'(desc_tgt);
                mask <= bcast ? '1 : N'(1) << desc_bank;
                adr  <= desc_adr;
                cnt  <= desc_len;
            end else if (hs) begin
                adr   <= adr + ADR_W'(1);
                cnt   <= cnt - LEN_W'(1);
                wadr  <= adr;
                wdata <= dat;
            end
        end
    end

endmodule

// File: rtl/lap_load_ctl.sv
// lap_load_ctl: host cache load sequencer; quiesces the SA, then streams words into col/row/partial banks.
// Optional broadcast to all banks of a type when LAP_LOAD_BCAST_EN is defined.
module lap_load_ctl
    import lap_load_ctl_pkg::*;
#(
    parameter int N      = LAP_N,
    parameter int ADR_W  = LAP_LOAD_ADR_W,
    parameter int DATA_W = 32,
    parameter int LEN_W  = LAP_LOAD_LEN_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 desc_valid,
    output logic                 desc_ready,
    input  logic [1:0]           desc_tgt,
    input  logic [$clog2(N)-1:0] desc_bank,
    input  logic [ADR_W-1:0]     desc_adr,
    input  logic [LEN_W-1:0]     desc_len,
`ifdef LAP_LOAD_BCAST_EN
    input  logic                 desc_bcast,
`endif
    input  logic                 dat_valid,
    output logic                 dat_ready,
    input  logic [DATA_W-1:0]    dat,
    output logic                 sa_hold,
    input  logic                 sa_busy,
    output logic [N-1:0]         col_wen,
    output logic [N-1:0]         row_wen,
    output logic [N-1:0]         par_wen,
    output logic [ADR_W-1:0]     wadr,
    output logic [DATA_W-1:0]    wdata,
    output logic                 done,
    output logic                 err
);

    load_state_t state;
    logic        ld, hs, bad, last, bcast;

    assign ld  = desc_valid & desc_ready;
    assign hs  = dat_valid & dat_ready;
    assign bad = desc_tgt == 2'd3 || desc_len == '0;
`ifdef LAP_LOAD_BCAST_EN
    assign bcast = desc_bcast;
`else
    assign bcast = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            desc_ready <= 1'b1;
            dat_ready  <= 1'b0;
            sa_hold    <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: if (ld) begin
                    if (bad) begin
                        err <= 1'b1;
                    end else begin
                        state      <= QUIESCE;
                        desc_ready <= 1'b0;
                        sa_hold    <= 1'b1;
                    end
                end
                QUIESCE: if (!sa_busy) begin
                    state     <= LOAD;
                    dat_ready <= 1'b1;
                end
                LOAD: if (hs && last) begin
                    state     <= DONE;
                    dat_ready <= 1'b0;
                    done      <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    sa_hold    <= 1'b0;
                    desc_ready <= 1'b1;
                end
            endcase
        end
    end

    lap_load_wgen #(.N(N), .ADR_W(ADR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) u_wgen (
        .clk       (clk),
        .reset     (reset),
        .ld        (ld),
        .desc_tgt  (desc_tgt),
        .desc_bank (desc_bank),
        .desc_adr  (desc_adr),
        .desc_len  (desc_len),
        .bcast     (bcast),
        .hs        (hs),
        .dat       (dat),
        .col_wen   (col_wen),
        .row_wen   (row_wen),
        .par_wen   (par_wen),
        .wadr      (wadr),
        .wdata     (wdata),
        .last      (last)
    );

endmodule

// File: doc/lap_load_ctl.md
Name: lap_load_ctl

Overview:
- Host-side cache load sequencer for the LAP systolic array.
- Accepts a load descriptor (target cache, bank, start address, length), then a stream of data words.
- Drives the write ports of the per-column col/row/partial SRAM banks.
- Quiesces the SA instruction path first (hold/busy handshake with the instruction controller), so array reads and partial-sum writebacks never overlap a load.

Parameters:
- N, 4, number of banks per cache type (matches LAP_N)
- ADR_W, 8, cache address width (max of col/row/par address bits)
- DATA_W, 32, load word width; col/row banks take low LAP_SA_ALUWIDTH bits, partial banks take all bits
- LEN_W, 9, descriptor length width (ADR_W+1, so a full bank can be loaded)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- desc_valid  in  1  descriptor offered
- desc_ready  out  1  descriptor accepted when valid&ready
- desc_tgt  in  2  0=col, 1=row, 2=part, 3=illegal
- desc_bank  in  $clog2(N)  target bank index
- desc_adr  in  ADR_W  start address
- desc_len  in  LEN_W  word count
- dat_valid  in  1  data word offered
- dat_ready  out  1  data word consumed when valid&ready
- dat  in  DATA_W  data word
- sa_hold  out  1  request that the SA controller stop issuing (drives iavail gating)
- sa_busy  in  1  SA pipeline still has in-flight reads/writebacks
- col_wen  out  N  per-bank write enable, col caches
- row_wen  out  N  per-bank write enable, row caches
- par_wen  out  N  per-bank write enable, partial caches
- wadr  out  ADR_W  shared write address
- wdata  out  DATA_W  shared write data
- done  out  1  one-cycle pulse: load finished
- err  out  1  one-cycle pulse: descriptor rejected

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE. All outputs 0 except desc_ready=1. Counters cleared. An in-flight load is abandoned with no done pulse, and all wen drop in the next cycle.
- States:
  - IDLE: desc_ready=1. On accept, latch the descriptor.
    - tgt==3 or len==0: pulse err next cycle, stay IDLE, consume no data.
    - Otherwise go to QUIESCE.
  - QUIESCE: sa_hold=1, desc_ready=0. Go to LOAD on the first cycle sa_busy==0.
  - LOAD: sa_hold=1, dat_ready=1.
    - Each dat handshake issues one registered write the following cycle: exactly one wen bit set (selected target, selected bank), wadr = current address, wdata = dat.
    - Address increments modulo 2^ADR_W: 0xFF+1 wraps to 0x00.
    - Remaining count decrements per handshake. On the handshake that takes it to 0, go to DONE.
    - Gaps in dat_valid insert idle cycles with all wen=0.
  - DONE: last write visible this cycle. done=1 for one cycle. sa_hold drops next cycle. Return to IDLE.
- Latency: dat handshake at cycle t → wen/wadr/wdata at t+1. Descriptor accept at t → earliest dat_ready at t+2 (QUIESCE takes at least one cycle).
- sa_hold stays high from QUIESCE through DONE inclusive. sa_busy is ignored after LOAD entry; SA must honour hold.
- desc_valid held during LOAD is not accepted until IDLE.
- Simultaneous err and done cannot occur.
- wen never asserted outside LOAD/DONE.

Optional Feature:
- Macro LAP_LOAD_BCAST_EN.
- Defined: adds input desc_bcast (1). When set at accept, every write asserts all N wen bits of the target type (desc_bank ignored), loading identical data into all banks.
- Undefined: port absent; exactly one wen bit per write.

Decomposition:
- proj_pkgs gets:
  - typedef load_tgt_t (enum COL, ROW, PART, ILL)
  - typedef load_desc_t (tgt, bank, adr, len)
  - constants LAP_LOAD_ADR_W and LAP_LOAD_LEN_W derived from the cache address bit constants
- One natural sub-module, lap_load_wgen: latched descriptor plus counters; emits wen/wadr/wdata from a dat handshake. The FSM stays in lap_load_ctl.

Test Plan:
- Basic load: sa_busy=0, desc{tgt=1,bank=2,adr=0x10,len=3}, dat=0xA,0xB,0xC back-to-back → row_wen=4'b0100 for 3 cycles at wadr 0x10,0x11,0x12 with data A,B,C; done pulses once; sa_hold high throughout.
- Quiesce: sa_busy=1 for 5 cycles after accept → dat_ready stays 0 and sa_hold=1 until sa_busy falls; first write follows; no wen before then.
- Wrap and bubbles: desc{tgt=2,bank=0,adr=0xFE,len=4}, dat_valid toggling 1,0,1,1,0,1 → par_wen[0] writes at 0xFE,0xFF,0x00,0x01; wen=0 in gap cycles.
- Errors: tgt=3 → err pulse, no sa_hold, no dat_ready. len=0 → same; next valid descriptor proceeds normally.
- Reset mid-load: reset=0 after 2 of 5 words → next cycle all wen=0, sa_hold=0, desc_ready=1, no done; a fresh load then completes.
- (LAP_LOAD_BCAST_EN) desc_bcast=1, tgt=0, len=2 → col_wen=4'b1111 on both writes.
